rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the inter-byte timeout in clk cycles (10 ms at 100 MHz).
REQ-002 The module SHALL have parameter MAX_LEN, default 4, meaning the maximum payload byte count (fixed at 4 in this revision).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port RxD_data, input, 8 bits: received byte, valid only while RxD_data_ready is high.
REQ-006 The module SHALL have port RxD_data_ready, input, 1 bit: one-cycle byte strobe from the UART receiver.
REQ-007 The module SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a good frame completes.
REQ-008 The module SHALL have port frame_cmd, output, 8 bits: command byte of the last good frame.
REQ-009 The module SHALL have port frame_len, output, 3 bits: payload length of the last good frame.
REQ-010 The module SHALL have port frame_payload, output, 32 bits: payload of the last good frame; byte 0 in [7:0], unused bytes zero.
REQ-011 The module SHALL have port frame_error, output, 1 bit: one-cycle pulse on a checksum error, bad length or timeout.

Function
REQ-012 Frame format SHALL be: SYNC (0xAA), CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-013 The state machine SHALL have states IDLE, GET_CMD, GET_LEN, GET_DATA and GET_CHK; a state advances only on a cycle with RxD_data_ready high.
REQ-014 IDLE: a byte equal to 0xAA SHALL go to GET_CMD; any other byte SHALL be discarded silently.
REQ-015 GET_CMD: the byte SHALL be latched as CMD, the running XOR SHALL be initialized to CMD, and the state SHALL go to GET_LEN.
REQ-016 GET_LEN, LEN = 0: the state SHALL go directly to GET_CHK.
REQ-017 GET_LEN, LEN 1..4: the state SHALL go to GET_DATA with the byte index cleared.
REQ-018 GET_LEN, LEN > 4: frame_error SHALL pulse and the state SHALL return to IDLE.
REQ-019 GET_DATA: each byte SHALL be stored at lane = index, folded into the XOR, and the index incremented; after byte LEN-1 the state SHALL go to GET_CHK.
REQ-020 Inside a frame, 0xAA SHALL be treated as ordinary data, with no resynchronization.
REQ-021 GET_CHK, match: frame_valid SHALL pulse in the cycle after the CHK strobe, frame_cmd/frame_len/frame_payload SHALL update in that same cycle, and the state SHALL return to IDLE.
REQ-022 GET_CHK, mismatch: frame_error SHALL pulse in the cycle after the CHK strobe, frame outputs SHALL keep their previous values, and the state SHALL return to IDLE.
REQ-023 frame_cmd, frame_len and frame_payload SHALL change only together with a frame_valid pulse.
REQ-024 The working payload buffer SHALL be zeroed on entry to GET_CMD, so payload lanes at or above LEN read zero.
REQ-025 Strobes on consecutive clock cycles SHALL each be consumed, with no byte lost.
REQ-026 frame_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-027 While rst is high at a clk edge: state SHALL be IDLE, index and XOR 0, timeout counter 0, and all outputs 0.
REQ-028 Reset mid-frame SHALL abort the frame with no frame_valid or frame_error pulse; the next byte after reset is parsed from IDLE.
REQ-029 rst SHALL take priority over a coincident RxD_data_ready.

Configuration
REQ-030 Macro RX_FRAME_PARSER_TIMEOUT_EN defined: a counter SHALL clear on every strobe and in IDLE, and SHALL count up each cycle in any other state.
REQ-031 With the macro defined, reaching TIMEOUT_CYCLES-1 SHALL pulse frame_error and return the state to IDLE.
REQ-032 With the macro defined, a strobe in the same cycle as expiry SHALL win: the byte is consumed and no timeout occurs.
REQ-033 Macro RX_FRAME_PARSER_TIMEOUT_EN undefined: no counter SHALL be built, and a partial frame SHALL wait indefinitely.

Verification
REQ-034 Bytes AA 10 02 34 12 34 -> one frame_valid pulse; cmd=0x10, len=2, payload=0x00001234.
REQ-035 Bytes AA 05 00 05 -> frame_valid; cmd=0x05, len=0, payload=0x00000000.
REQ-036 Bytes AA 10 02 34 12 00 -> frame_error pulse; outputs keep the prior frame's values.
REQ-037 Bytes AA 01 07 -> frame_error after the LEN byte; a following AA 20 01 AA 8B -> frame_valid with payload=0x000000AA.
REQ-038 Bytes AA 10 then idle for TIMEOUT_CYCLES=16 (macro defined) -> frame_error; a subsequent full frame decodes correctly.
REQ-039 rst asserted after AA 10 02 34, then 12 34 sent -> no pulse, because the parser is back in IDLE and discards both bytes.

Source files
------------

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: UART byte-stream frame decoder.
// Frame layout: 0xAA, CMD, LEN (0..MAX_LEN), LEN payload bytes, CHK.
// CHK is the XOR of CMD, LEN and every payload byte.
// Optional inter-byte timeout: define RX_FRAME_PARSER_TIMEOUT_EN.
module rx_frame_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_LEN        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  RxD_data,
  input  logic        RxD_data_ready,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [2:0]  frame_len,
  output logic [31:0] frame_payload,
  output logic        frame_error
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned PAY_W  = 32;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_DATA,
    GET_CHK
  } state_t;

  state_t             state,      stateNext;
  logic [BYTE_W-1:0]  cmdReg,     cmdNext;
  logic [LEN_W-1:0]   lenReg,     lenNext;
  logic [IDX_W-1:0]   idxReg,     idxNext;
  logic [BYTE_W-1:0]  xorReg,     xorNext;
  logic [PAY_W-1:0]   bufReg,     bufNext;

  logic               validNext;
  logic               errorNext;
  logic [BYTE_W-1:0]  frameCmdNext;
  logic [LEN_W-1:0]   frameLenNext;
  logic [PAY_W-1:0]   framePayloadNext;

`ifdef RX_FRAME_PARSER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] timeoutCnt, timeoutCntNext;
`else
  // Timeout length has no effect when the timer is not built.
  logic unusedTimeout;
  assign unusedTimeout = ^32'(TIMEOUT_CYCLES);
`endif

  // State, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmdReg        <= '0;
      lenReg        <= '0;
      idxReg        <= '0;
      xorReg        <= '0;
      bufReg        <= '0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
`ifdef RX_FRAME_PARSER_TIMEOUT_EN
      timeoutCnt    <= '0;
`endif
    end else begin
      state         <= stateNext;
      cmdReg        <= cmdNext;
      lenReg        <= lenNext;
      idxReg        <= idxNext;
      xorReg        <= xorNext;
      bufReg        <= bufNext;
      frame_valid   <= validNext;
      frame_error   <= errorNext;
      frame_cmd     <= frameCmdNext;
      frame_len     <= frameLenNext;
      frame_payload <= framePayloadNext;
`ifdef RX_FRAME_PARSER_TIMEOUT_EN
      timeoutCnt    <= timeoutCntNext;
`endif
    end
  end

  // Next-state decode, byte capture, checksum and output pulses.
  always_comb begin
    stateNext        = state;
    cmdNext          = cmdReg;
    lenNext          = lenReg;
    idxNext          = idxReg;
    xorNext          = xorReg;
    bufNext          = bufReg;
    validNext        = 1'b0;
    errorNext        = 1'b0;
    frameCmdNext     = frame_cmd;
    frameLenNext     = frame_len;
    framePayloadNext = frame_payload;
`ifdef RX_FRAME_PARSER_TIMEOUT_EN
    timeoutCntNext   = '0;
`endif

    if (RxD_data_ready) begin
      case (state)
        IDLE: begin
          if (RxD_data == SYNC_BYTE) begin
            bufNext   = '0;
            stateNext = GET_CMD;
          end
        end

        GET_CMD: begin
          cmdNext   = RxD_data;
          xorNext   = RxD_data;
          stateNext = GET_LEN;
        end

        GET_LEN: begin
          lenNext = RxD_data[LEN_W-1:0];
          xorNext = xorReg ^ RxD_data;
          idxNext = '0;
          if (RxD_data == '0) begin
            stateNext = GET_CHK;
          end else if (RxD_data <= BYTE_W'(MAX_LEN)) begin
            stateNext = GET_DATA;
          end else begin
            errorNext = 1'b1;
            stateNext = IDLE;
          end
        end

        GET_DATA: begin
          bufNext[{idxReg, 3'b000} +: BYTE_W] = RxD_data;
          xorNext = xorReg ^ RxD_data;
          idxNext = idxReg + IDX_W'(1);
          if ((LEN_W'(idxReg) + LEN_W'(1)) == lenReg) begin
            stateNext = GET_CHK;
          end
        end

        GET_CHK: begin
          if (RxD_data == xorReg) begin
            validNext        = 1'b1;
            frameCmdNext     = cmdReg;
            frameLenNext     = lenReg;
            framePayloadNext = bufReg;
          end else begin
            errorNext = 1'b1;
          end
          stateNext = IDLE;
        end

        default: stateNext = IDLE;
      endcase
`ifdef RX_FRAME_PARSER_TIMEOUT_EN
    end else if (state != IDLE) begin
      // Silence inside a frame: count, and abandon the frame on expiry.
      if (timeoutCnt == CNT_LAST) begin
        errorNext      = 1'b1;
        stateNext      = IDLE;
        timeoutCntNext = '0;
      end else begin
        timeoutCntNext = timeoutCnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed testbench for rx_frame_parser; also covers the timeout build
// when RX_FRAME_PARSER_TIMEOUT_EN is defined.
module tb_rx_frame_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  RxD_data;
  logic        RxD_data_ready;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [2:0]  frame_len;
  logic [31:0] frame_payload;
  logic        frame_error;

  int errors = 0;
  int checks = 0;

  rx_frame_parser #(
    .TIMEOUT_CYCLES(16),
    .MAX_LEN       (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RxD_data      (RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .frame_valid   (frame_valid),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .frame_payload (frame_payload),
    .frame_error   (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte strobe for the next rising edge.
  task automatic putByte(input logic [7:0] b);
    @(negedge clk);
    RxD_data       = b;
    RxD_data_ready = 1'b1;
  endtask

  // One idle cycle; outputs seen here reflect the previous rising edge.
  task automatic quiet();
    @(negedge clk);
    RxD_data       = 8'h00;
    RxD_data_ready = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] cmd,
                            input logic [2:0] len, input logic [31:0] pay);
    check({tag, "_valid"}, 32'(frame_valid), 32'd1);
    check({tag, "_error"}, 32'(frame_error), 32'd0);
    check({tag, "_cmd"},   32'(frame_cmd),   32'(cmd));
    check({tag, "_len"},   32'(frame_len),   32'(len));
    check({tag, "_pay"},   frame_payload,    pay);
  endtask

  int waitCycles;
  bit seenError;
  bit seenValid;

  initial begin
    rst            = 1'b1;
    RxD_data       = 8'h00;
    RxD_data_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);
    check("rst_cmd",   32'(frame_cmd),   32'd0);
    check("rst_len",   32'(frame_len),   32'd0);
    check("rst_pay",   frame_payload,    32'd0);
    rst = 1'b0;

    // Two-byte frame, back-to-back strobes.
    putByte(8'hAA); putByte(8'h10); putByte(8'h02);
    putByte(8'h34); putByte(8'h12); putByte(8'h34);
    quiet();
    checkFrame("f2", 8'h10, 3'd2, 32'h0000_1234);
    quiet();
    check("f2_pulse_end", 32'(frame_valid), 32'd0);

    // Bad checksum: error pulse, outputs hold.
    putByte(8'hAA); putByte(8'h10); putByte(8'h02);
    putByte(8'h34); putByte(8'h12); putByte(8'h00);
    quiet();
    check("chk_error", 32'(frame_error), 32'd1);
    check("chk_valid", 32'(frame_valid), 32'd0);
    check("chk_cmd",   32'(frame_cmd),   32'h10);
    check("chk_len",   32'(frame_len),   32'd2);
    check("chk_pay",   frame_payload,    32'h0000_1234);
    quiet();
    check("chk_pulse_end", 32'(frame_error), 32'd0);

    // Zero-length frame; payload buffer must read zero.
    putByte(8'hAA); putByte(8'h05); putByte(8'h00); putByte(8'h05);
    quiet();
    checkFrame("f0", 8'h05, 3'd0, 32'h0000_0000);

    // LEN=7 rejected right after the LEN byte.
    putByte(8'hAA); putByte(8'h01); putByte(8'h07);
    quiet();
    check("len7_error", 32'(frame_error), 32'd1);
    check("len7_valid", 32'(frame_valid), 32'd0);

    // 0xAA inside a frame is plain data.
    putByte(8'hAA); putByte(8'h20); putByte(8'h01); putByte(8'hAA); putByte(8'h8B);
    quiet();
    checkFrame("f1aa", 8'h20, 3'd1, 32'h0000_00AA);

    // LEN=5 is one past the limit.
    putByte(8'hAA); putByte(8'h01); putByte(8'h05);
    quiet();
    check("len5_error", 32'(frame_error), 32'd1);

    // Junk in IDLE, then a maximum-length frame with spaced strobes.
    putByte(8'h55); putByte(8'h00);
    putByte(8'hAA); quiet(); putByte(8'h33); putByte(8'h04);
    putByte(8'h11); quiet(); putByte(8'h22); putByte(8'h33);
    quiet(); quiet(); putByte(8'h44); putByte(8'h73);
    quiet();
    checkFrame("f4", 8'h33, 3'd4, 32'h4433_2211);

`ifdef RX_FRAME_PARSER_TIMEOUT_EN
    // Silence after CMD: error on the 16th idle edge.
    putByte(8'hAA); putByte(8'h10);
    quiet();
    seenError  = 1'b0;
    waitCycles = 0;
    for (int i = 1; i <= 40; i++) begin
      quiet();
      if (frame_error) begin
        seenError  = 1'b1;
        waitCycles = i;
        break;
      end
    end
    check("to_seen",   32'(seenError),  32'd1);
    check("to_cycles", 32'(waitCycles), 32'd16);
    quiet();
    check("to_pulse_end", 32'(frame_error), 32'd0);

    // Strobe on the expiry edge wins.
    putByte(8'hAA); putByte(8'h10);
    seenError = 1'b0;
    for (int i = 0; i < 15; i++) begin
      quiet();
      if (frame_error) seenError = 1'b1;
    end
    putByte(8'h00);
    putByte(8'h10);
    quiet();
    check("to_race_noerr", 32'(seenError | frame_error), 32'd0);
    checkFrame("to_race", 8'h10, 3'd0, 32'h0);
`else
    // No timer: a partial frame waits indefinitely.
    putByte(8'hAA); putByte(8'h10);
    seenError = 1'b0;
    for (int i = 0; i < 40; i++) begin
      quiet();
      if (frame_error) seenError = 1'b1;
    end
    check("nto_noerr", 32'(seenError), 32'd0);
    putByte(8'h00); putByte(8'h10);
    quiet();
    checkFrame("nto", 8'h10, 3'd0, 32'h0);
`endif

    // Full frame decodes after the above.
    putByte(8'hAA); putByte(8'h10); putByte(8'h02);
    putByte(8'h34); putByte(8'h12); putByte(8'h34);
    quiet();
    checkFrame("after", 8'h10, 3'd2, 32'h0000_1234);

    // Reset mid-frame aborts silently; remaining bytes are discarded.
    putByte(8'hAA); putByte(8'h10); putByte(8'h02); putByte(8'h34);
    quiet();
    rst = 1'b1;
    quiet();
    rst = 1'b0;
    check("mid_rst_cmd", 32'(frame_cmd), 32'd0);
    putByte(8'h12); putByte(8'h34);
    seenValid = 1'b0;
    seenError = 1'b0;
    for (int i = 0; i < 3; i++) begin
      quiet();
      if (frame_valid) seenValid = 1'b1;
      if (frame_error) seenError = 1'b1;
    end
    check("mid_rst_valid", 32'(seenValid), 32'd0);
    check("mid_rst_error", 32'(seenError), 32'd0);

    // Reset beats a coincident sync strobe.
    putByte(8'hAA);
    rst = 1'b1;
    quiet();
    rst = 1'b0;
    putByte(8'h10); putByte(8'h00); putByte(8'h10);
    quiet();
    check("rst_prio_valid", 32'(frame_valid), 32'd0);
    putByte(8'hAA); putByte(8'h05); putByte(8'h00); putByte(8'h05);
    quiet();
    checkFrame("rst_prio_next", 8'h05, 3'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
